decode_stage: RTL and testbench

Instruction-decode stage of the pipelined MIPS CPU; sits directly downstream of instruction fetch, consuming the fetched PC/instruction pair. Holds the 32x32 register file, splits the instruction into fields, reads operands, and detects load-use hazards, stalling fetch for one cycle. Results are registered into the ID/EX pipeline register that feeds execute.

---
 rtl/decode_stage.sv | 126 ++++++++++++
 tb/tb_decode_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction-decode stage: 32x32 register file with write bypass, field split,
// load-use hazard detection and the ID/EX pipeline register feeding execute.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] ins_in,
  input  logic        valid_in,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [5:0]  op_out,
  output logic [5:0]  funct_out,
  output logic [4:0]  rs_out,
  output logic [4:0]  rt_out,
  output logic [4:0]  dest_out,
  output logic [31:0] imm_out,
  output logic [31:0] rs_data_out,
  output logic [31:0] rt_data_out,
  output logic        is_load_out
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        is_load;
  } idex_t;

  logic [31:0] rf_q [32];
  idex_t       idex_q, idex_d;

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, dest;
  logic [31:0] imm, rs_val, rt_val;
  logic        rs_src, rt_src, hazard;

  assign op = ins_in[31:26];
  assign rs = ins_in[25:21];
  assign rt = ins_in[20:16];
  assign rd = ins_in[15:11];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // $0 reads as zero regardless of the array; a same-cycle write wins over the array
  always_comb begin
    rs_val = rf_q[rs];
    rt_val = rf_q[rt];
    if (wb_en && wb_addr == rs) rs_val = wb_data;
    if (wb_en && wb_addr == rt) rt_val = wb_data;
    if (rs == 5'd0) rs_val = '0;
    if (rt == 5'd0) rt_val = '0;
  end

  always_comb begin
    dest   = rt;
    imm    = {{16{ins_in[15]}}, ins_in[15:0]};
    rs_src = 1'b1;
    rt_src = 1'b0;
    case (op)
      6'h00: begin dest = rd; rt_src = 1'b1; end
      6'h02: begin dest = 5'd0; rs_src = 1'b0; end
      6'h03: begin dest = 5'd31; rs_src = 1'b0; end
      6'h04, 6'h05, 6'h2B: begin dest = 5'd0; rt_src = 1'b1; end
      6'h0C, 6'h0D, 6'h0E: imm = {16'h0000, ins_in[15:0]};
      default: ;
    endcase
  end

  assign hazard = idex_q.valid && idex_q.is_load && (idex_q.dest != 5'd0) &&
                  valid_in && !flush &&
                  ((rs_src && rs == idex_q.dest) || (rt_src && rt == idex_q.dest));
  assign stall_out = hazard;

  always_comb begin
    idex_d = '0;
    if (valid_in && !flush && !hazard) begin
      idex_d.valid   = 1'b1;
      idex_d.pc      = pc_in;
      idex_d.op      = op;
      idex_d.funct   = ins_in[5:0];
      idex_d.rs      = rs;
      idex_d.rt      = rt;
      idex_d.dest    = dest;
      idex_d.imm     = imm;
      idex_d.rs_data = rs_val;
      idex_d.rt_data = rt_val;
      idex_d.is_load = (op == 6'h23);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign valid_out   = idex_q.valid;
  assign pc_out      = idex_q.pc;
  assign op_out      = idex_q.op;
  assign funct_out   = idex_q.funct;
  assign rs_out      = idex_q.rs;
  assign rt_out      = idex_q.rt;
  assign dest_out    = idex_q.dest;
  assign imm_out     = idex_q.imm;
  assign rs_data_out = idex_q.rs_data;
  assign rt_data_out = idex_q.rt_data;
  assign is_load_out = idex_q.is_load;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, reset-mid-stall sequence and a
// randomized run, all checked against a behavioural model of the decode rules.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, ins_in, wb_data;
  logic        valid_in, flush, wb_en;
  logic [4:0]  wb_addr;
  logic        stall_out, valid_out, is_load_out;
  logic [31:0] pc_out, imm_out, rs_data_out, rt_data_out;
  logic [5:0]  op_out, funct_out;
  logic [4:0]  rs_out, rt_out, dest_out;

  decode_stage dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .ins_in(ins_in), .valid_in(valid_in),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall_out(stall_out), .valid_out(valid_out), .pc_out(pc_out), .op_out(op_out),
    .funct_out(funct_out), .rs_out(rs_out), .rt_out(rt_out), .dest_out(dest_out),
    .imm_out(imm_out), .rs_data_out(rs_data_out), .rt_data_out(rt_data_out),
    .is_load_out(is_load_out)
  );

  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          v;
    logic [31:0] pc, imm, rsd, rtd;
    int          op, funct, rs, rt, dest;
    bit          ld;
  } mstate_t;

  logic [31:0] mrf [32];
  mstate_t     m, m_next;
  bit          m_stall;

  function automatic logic [31:0] mread(input int r);
    if (r == 0) return 0;
    if (wb_en && int'(wb_addr) == r) return wb_data;
    return mrf[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mrf[i] = 0;
    m = '{default: 0};
  endtask

  task automatic model_eval();
    int op, rs, rt;
    bit uses_rs, uses_rt;
    op = int'(ins_in / 32'h0400_0000);
    rs = int'(ins_in / 32'h0020_0000) % 32;
    rt = int'(ins_in / 32'h0001_0000) % 32;
    uses_rs = !(op == 2 || op == 3);
    uses_rt = (op == 0 || op == 4 || op == 5 || op == 'h2B);
    m_stall = m.v && m.ld && m.dest != 0 && valid_in && !flush &&
              ((uses_rs && rs == m.dest) || (uses_rt && rt == m.dest));
    m_next = '{default: 0};
    if (valid_in && !flush && !m_stall) begin
      m_next.v     = 1;
      m_next.pc    = pc_in;
      m_next.op    = op;
      m_next.funct = int'(ins_in % 64);
      m_next.rs    = rs;
      m_next.rt    = rt;
      if (op == 0)                                     m_next.dest = int'(ins_in / 2048) % 32;
      else if (op == 3)                                m_next.dest = 31;
      else if (op == 2 || op == 4 || op == 5 || op == 'h2B) m_next.dest = 0;
      else                                             m_next.dest = rt;
      if (op >= 'h0C && op <= 'h0E) m_next.imm = ins_in % 65536;
      else m_next.imm = 32'(longint'($signed(ins_in[15:0])));
      m_next.rsd = mread(rs);
      m_next.rtd = mread(rt);
      m_next.ld  = (op == 'h23);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"},   32'(valid_out),   32'(m.v));
    chk({tag, ".pc"},      pc_out,           m.pc);
    chk({tag, ".op"},      32'(op_out),      32'(m.op));
    chk({tag, ".funct"},   32'(funct_out),   32'(m.funct));
    chk({tag, ".rs"},      32'(rs_out),      32'(m.rs));
    chk({tag, ".rt"},      32'(rt_out),      32'(m.rt));
    chk({tag, ".dest"},    32'(dest_out),    32'(m.dest));
    chk({tag, ".imm"},     imm_out,          m.imm);
    chk({tag, ".rs_data"}, rs_data_out,      m.rsd);
    chk({tag, ".rt_data"}, rt_data_out,      m.rtd);
    chk({tag, ".is_load"}, 32'(is_load_out), 32'(m.ld));
  endtask

  // One decode cycle; called just after a negedge, returns just after the next negedge.
  task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                      input bit v, input bit fl, input bit we, input logic [4:0] wa,
                      input logic [31:0] wd, output bit stall_seen);
    ins_in = ins; pc_in = pc; valid_in = v; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    model_eval();
    stall_seen = stall_out;
    chk({tag, ".stall"}, 32'(stall_out), 32'(m_stall));
    @(posedge clk);
    if (we && wa != 0) mrf[wa] = wd;
    m = m_next;
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] ins;
    bit          v, fl, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          e_stall, e_v;
    logic [4:0]  e_dest;
    logic [31:0] e_imm, e_rsd, e_rtd;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic [31:0] ins, input bit v, input bit fl, input bit we,
                              input logic [4:0] wa, input logic [31:0] wd, input bit es,
                              input bit ev, input logic [4:0] ed, input logic [31:0] ei,
                              input logic [31:0] ers, input logic [31:0] ert);
    vec_t r;
    r.ins = ins; r.v = v; r.fl = fl; r.we = we; r.wa = wa; r.wd = wd;
    r.e_stall = es; r.e_v = ev; r.e_dest = ed; r.e_imm = ei; r.e_rsd = ers; r.e_rtd = ert;
    return r;
  endfunction

  initial begin
    bit st;
    int stall_cycles;
    logic [31:0] ins_r, pc_r;
    int ops [12];

    tbl[0]  = mk(32'h0000_0000, 0, 0, 0, 5'd0, 32'h0,         0, 0, 5'd0,  32'h0,         32'h0,         32'h0);
    tbl[1]  = mk(32'h0000_0000, 0, 0, 1, 5'd5, 32'hDEADBEEF,  0, 0, 5'd0,  32'h0,         32'h0,         32'h0);
    tbl[2]  = mk(32'h00A0_1820, 1, 0, 0, 5'd0, 32'h0,         0, 1, 5'd3,  32'h0000_1820, 32'hDEADBEEF,  32'h0);
    tbl[3]  = mk(32'h00E0_4020, 1, 0, 1, 5'd7, 32'h1234,      0, 1, 5'd8,  32'h0000_4020, 32'h0000_1234, 32'h0);
    tbl[4]  = mk(32'h0000_0020, 1, 0, 1, 5'd0, 32'hFFFFFFFF,  0, 1, 5'd0,  32'h0000_0020, 32'h0,         32'h0);
    tbl[5]  = mk(32'h0000_0020, 1, 0, 0, 5'd0, 32'h0,         0, 1, 5'd0,  32'h0000_0020, 32'h0,         32'h0);
    tbl[6]  = mk(32'h2122_FFFC, 1, 0, 0, 5'd0, 32'h0,         0, 1, 5'd2,  32'hFFFF_FFFC, 32'h0,         32'h0);
    tbl[7]  = mk(32'h3522_FFFC, 1, 0, 0, 5'd0, 32'h0,         0, 1, 5'd2,  32'h0000_FFFC, 32'h0,         32'h0);
    tbl[8]  = mk(32'h8D28_0004, 1, 0, 0, 5'd0, 32'h0,         0, 1, 5'd8,  32'h0000_0004, 32'h0,         32'h0);
    tbl[9]  = mk(32'h0108_5020, 1, 0, 0, 5'd0, 32'h0,         1, 0, 5'd0,  32'h0,         32'h0,         32'h0);
    tbl[10] = mk(32'h0108_5020, 1, 0, 0, 5'd0, 32'h0,         0, 1, 5'd10, 32'h0000_5020, 32'h0,         32'h0);
    tbl[11] = mk(32'h8D28_0004, 1, 0, 0, 5'd0, 32'h0,         0, 1, 5'd8,  32'h0000_0004, 32'h0,         32'h0);
    tbl[12] = mk(32'h8D2A_0000, 1, 0, 0, 5'd0, 32'h0,         0, 1, 5'd10, 32'h0,         32'h0,         32'h0);
    tbl[13] = mk(32'h8D28_0004, 1, 0, 0, 5'd0, 32'h0,         0, 1, 5'd8,  32'h0000_0004, 32'h0,         32'h0);
    tbl[14] = mk(32'h8D28_0000, 1, 0, 0, 5'd0, 32'h0,         0, 1, 5'd8,  32'h0,         32'h0,         32'h0);
    tbl[15] = mk(32'h0108_5020, 1, 1, 0, 5'd0, 32'h0,         0, 0, 5'd0,  32'h0,         32'h0,         32'h0);
    tbl[16] = mk(32'h8D28_0004, 1, 0, 0, 5'd0, 32'h0,         0, 1, 5'd8,  32'h0000_0004, 32'h0,         32'h0);
    tbl[17] = mk(32'h0D00_0010, 1, 0, 0, 5'd0, 32'h0,         0, 1, 5'd31, 32'h0000_0010, 32'h0,         32'h0);
    tbl[18] = mk(32'h0C00_0010, 1, 0, 0, 5'd0, 32'h0,         0, 1, 5'd31, 32'h0000_0010, 32'h0,         32'h0);

    // reset with random inputs
    reset = 1'b0;
    ins_in = $urandom; pc_in = $urandom; valid_in = 1'b1; flush = 1'b0;
    wb_en = 1'b1; wb_addr = 5'($urandom_range(1, 31)); wb_data = $urandom;
    model_reset();
    #12;
    chk("reset.stall", 32'(stall_out), 32'h0);
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    step("idle", 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, st);
    step("idle2", $urandom, $urandom, 0, 0, 0, 5'd0, 32'h0, st);

    for (int i = 0; i < 19; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tag, tbl[i].ins, 32'h400 + 32'(i * 4), tbl[i].v, tbl[i].fl, tbl[i].we,
           tbl[i].wa, tbl[i].wd, st);
      chk({tag, ".tstall"}, 32'(st), 32'(tbl[i].e_stall));
      chk({tag, ".tvalid"}, 32'(valid_out), 32'(tbl[i].e_v));
      chk({tag, ".tdest"}, 32'(dest_out), 32'(tbl[i].e_dest));
      chk({tag, ".timm"}, imm_out, tbl[i].e_imm);
      chk({tag, ".trsd"}, rs_data_out, tbl[i].e_rsd);
      chk({tag, ".trtd"}, rt_data_out, tbl[i].e_rtd);
    end

    // load-use stall lasts exactly one cycle with fetch holding
    step("lu_lw", 32'h8D28_0004, 32'h800, 1, 0, 0, 5'd0, 32'h0, st);
    stall_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      step("lu_add", 32'h0108_5020, 32'h804, 1, 0, 0, 5'd0, 32'h0, st);
      if (st) stall_cycles++;
      else break;
    end
    chk("lu.stall_cycles", 32'(stall_cycles), 32'd1);
    chk("lu.dest_after", 32'(dest_out), 32'd10);

    // reset mid-stall clears state at once and drops stall_out
    step("rm_wb", 32'h0, 32'h0, 0, 0, 1, 5'd5, 32'hCAFE_F00D, st);
    step("rm_lw", 32'h8D28_0004, 32'h900, 1, 0, 0, 5'd0, 32'h0, st);
    ins_in = 32'h0108_5020; pc_in = 32'h904; valid_in = 1'b1; flush = 1'b0; wb_en = 1'b0;
    #1;
    chk("rm.stall_before", 32'(stall_out), 32'h1);
    reset = 1'b0;
    #1;
    model_reset();
    chk("rm.stall_after", 32'(stall_out), 32'h0);
    check_outputs("rm");
    @(negedge clk);
    reset = 1'b1;
    step("rm_rf_clear", 32'h00A0_1820, 32'h908, 1, 0, 0, 5'd0, 32'h0, st);
    chk("rm.rf_cleared", rs_data_out, 32'h0);

    // randomized run against the model; fetch holds the instruction while stalled
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h23, 6'h2B};
    ins_r = 32'h0; pc_r = 32'h1000;
    st = 0;
    for (int n = 0; n < 500; n++) begin
      if (!st) begin
        ins_r = {6'(ops[$urandom_range(0, 11)]), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 16'($urandom)};
        pc_r = pc_r + 4;
      end
      step($sformatf("rnd%0d", n), ins_r, pc_r, $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
